// File: rtl/conformador_pulso.sv
// Push-button front end: two-flop synchronizer, debounce filter and
// single-cycle press pulse with optional auto-repeat while held.
module conformador_pulso #(
   parameter int unsigned CICLOS_FILTRO             = 1_000_000,
   parameter int unsigned CICLOS_REPETICION_INICIAL = 50_000_000,
   parameter int unsigned CICLOS_REPETICION         = 25_000_000,
   parameter int unsigned HABILITAR_REPETICION      = 1,
   parameter int unsigned N_BITS                    = 26
) (
   input  logic clk,
   input  logic reset,
   input  logic botonEntrada,
   output logic pulsoSalida,
   output logic nivelEstable
);

   typedef enum logic [1:0] {
      REPOSO,
      FILTRO_PRESION,
      PRESIONADO,
      FILTRO_LIBERACION
   } estado_t;

   localparam logic [N_BITS-1:0] FILTRO_MAX     = N_BITS'(CICLOS_FILTRO - 1);
   localparam logic [N_BITS-1:0] REP_INICIAL_MAX = N_BITS'(CICLOS_REPETICION_INICIAL - 1);
   localparam logic [N_BITS-1:0] REP_MAX         = N_BITS'(CICLOS_REPETICION - 1);

   estado_t           estado_q, estado_d;
   logic [N_BITS-1:0] contador_q, contador_d;
   logic              primera_q, primera_d;
   logic              pulso_q, pulso_d;
   logic              nivel_q, nivel_d;
   logic              s1_q, s2_q;
   logic              sinc;
   logic [N_BITS-1:0] limite;

   assign sinc   = s2_q;
   assign limite = primera_q ? REP_INICIAL_MAX : REP_MAX;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         estado_q   <= REPOSO;
         contador_q <= '0;
         primera_q  <= 1'b0;
         pulso_q    <= 1'b0;
         nivel_q    <= 1'b0;
      end else begin
         s1_q       <= botonEntrada;
         s2_q       <= s1_q;
         estado_q   <= estado_d;
         contador_q <= contador_d;
         primera_q  <= primera_d;
         pulso_q    <= pulso_d;
         nivel_q    <= nivel_d;
      end
   end

   always_comb begin
      estado_d   = estado_q;
      contador_d = contador_q;
      primera_d  = primera_q;
      nivel_d    = nivel_q;
      pulso_d    = 1'b0;
      case (estado_q)
         REPOSO: begin
            if (sinc) begin
               estado_d   = FILTRO_PRESION;
               contador_d = '0;
            end
         end
         FILTRO_PRESION: begin
            if (!sinc) begin
               estado_d   = REPOSO;
               contador_d = '0;
            end else if (contador_q == FILTRO_MAX) begin
               estado_d   = PRESIONADO;
               contador_d = '0;
               primera_d  = 1'b1;
               nivel_d    = 1'b1;
               pulso_d    = 1'b1;
            end else begin
               contador_d = contador_q + N_BITS'(1);
            end
         end
         PRESIONADO: begin
            if (!sinc) begin
               estado_d   = FILTRO_LIBERACION;
               contador_d = '0;
            end else if (HABILITAR_REPETICION != 0) begin
               if (contador_q == limite) begin
                  pulso_d    = 1'b1;
                  contador_d = '0;
                  primera_d  = 1'b0;
               end else begin
                  contador_d = contador_q + N_BITS'(1);
               end
            end else begin
               contador_d = '0;
            end
         end
         FILTRO_LIBERACION: begin
            // A bounce back to pressed restarts the repeat timer without a pulse.
            if (sinc) begin
               estado_d   = PRESIONADO;
               contador_d = '0;
               primera_d  = 1'b1;
            end else if (contador_q == FILTRO_MAX) begin
               estado_d   = REPOSO;
               contador_d = '0;
               nivel_d    = 1'b0;
            end else begin
               contador_d = contador_q + N_BITS'(1);
            end
         end
         default: begin
            estado_d   = REPOSO;
            contador_d = '0;
         end
      endcase
   end

   assign pulsoSalida  = pulso_q;
   assign nivelEstable = nivel_q;

endmodule

// File: tb/tb_conformador_pulso.sv
// Directed bench for conformador_pulso: one instance with auto-repeat,
// one without, both driven by the same button and reset.
module tb_conformador_pulso;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, boton;
   logic pulso_r, nivel_r, pulso_n, nivel_n;

   int e;
   int pr[$], pn[$], nr[$], nn[$];
   int esp[$];
   logic nivel_r_ant, nivel_n_ant;
   int pasadas = 0;
   int total   = 0;

   conformador_pulso #(
      .CICLOS_FILTRO(4),
      .CICLOS_REPETICION_INICIAL(10),
      .CICLOS_REPETICION(5),
      .HABILITAR_REPETICION(1),
      .N_BITS(8)
   ) dut_rep (
      .clk(clk),
      .reset(reset),
      .botonEntrada(boton),
      .pulsoSalida(pulso_r),
      .nivelEstable(nivel_r)
   );

   conformador_pulso #(
      .CICLOS_FILTRO(4),
      .CICLOS_REPETICION_INICIAL(10),
      .CICLOS_REPETICION(5),
      .HABILITAR_REPETICION(0),
      .N_BITS(8)
   ) dut_norep (
      .clk(clk),
      .reset(reset),
      .botonEntrada(boton),
      .pulsoSalida(pulso_n),
      .nivelEstable(nivel_n)
   );

   task automatic verificar(input string tag, input int obs, input int esperado);
      total++;
      if (obs == esperado) pasadas++;
      else $display("FAIL %s: obtenido=%0d esperado=%0d", tag, obs, esperado);
   endtask

   task automatic revisar(input string tag, input int obs[$], input int lista[$]);
      verificar({tag, "_cuenta"}, obs.size(), lista.size());
      foreach (lista[i])
         verificar($sformatf("%s_%0d", tag, i), (i < obs.size()) ? obs[i] : -1, lista[i]);
   endtask

   // Drive one cycle, sample #1 after the edge and log pulse/level-change edges.
   task automatic paso(input logic b, input logic r);
      boton = b;
      reset = r;
      @(posedge clk);
      #1;
      e++;
      if (pulso_r) pr.push_back(e);
      if (pulso_n) pn.push_back(e);
      if (nivel_r !== nivel_r_ant) nr.push_back(e);
      if (nivel_n !== nivel_n_ant) nn.push_back(e);
      nivel_r_ant = nivel_r;
      nivel_n_ant = nivel_n;
   endtask

   task automatic mantener(input logic b, input int n);
      repeat (n) paso(b, 1'b0);
   endtask

   task automatic inicio();
      e = 0;
      pr.delete();
      pn.delete();
      nr.delete();
      nn.delete();
   endtask

   initial begin
      boton       = 1'b0;
      reset       = 1'b1;
      nivel_r_ant = 1'b0;
      nivel_n_ant = 1'b0;
      e           = 0;
      repeat (3) paso(1'b0, 1'b1);
      verificar("rst_pulso_r", int'(pulso_r), 0);
      verificar("rst_nivel_r", int'(nivel_r), 0);
      verificar("rst_pulso_n", int'(pulso_n), 0);
      verificar("rst_nivel_n", int'(nivel_n), 0);
      mantener(1'b0, 3);

      // Clean press, no repeat: pulse and level rise at edge 7; release falls at 7.
      inicio();
      mantener(1'b1, 30);
      esp = {7};
      revisar("s1_pulso", pn, esp);
      revisar("s1_nivel", nn, esp);
      inicio();
      mantener(1'b0, 10);
      esp.delete();
      revisar("s1_lib_pulso", pn, esp);
      esp = {7};
      revisar("s1_lib_nivel", nn, esp);
      mantener(1'b0, 2);

      // Bounce shorter than the filter is rejected, then a real press.
      inicio();
      mantener(1'b1, 3);
      mantener(1'b0, 1);
      mantener(1'b1, 3);
      mantener(1'b0, 6);
      esp.delete();
      revisar("s2_reb_pulso_r", pr, esp);
      revisar("s2_reb_pulso_n", pn, esp);
      revisar("s2_reb_nivel_r", nr, esp);
      inicio();
      mantener(1'b1, 10);
      esp = {7};
      revisar("s2_pulso_r", pr, esp);
      revisar("s2_pulso_n", pn, esp);
      revisar("s2_nivel_r", nr, esp);
      mantener(1'b0, 12);

      // Auto-repeat: held so the synchronized level drops before edge 42.
      inicio();
      mantener(1'b1, 38);
      mantener(1'b0, 10);
      esp = {7, 17, 22, 27, 32, 37};
      revisar("s3_pulso_r", pr, esp);
      esp = {7, 45};
      revisar("s3_nivel_r", nr, esp);
      esp = {7};
      revisar("s3_pulso_n", pn, esp);
      mantener(1'b0, 2);

      // Two-cycle release glitch at edge 12: level held, repeat timer restarts at 16.
      inicio();
      mantener(1'b1, 11);
      mantener(1'b0, 2);
      mantener(1'b1, 15);
      mantener(1'b0, 10);
      esp = {7, 26};
      revisar("s4_pulso_r", pr, esp);
      esp = {7, 35};
      revisar("s4_nivel_r", nr, esp);
      revisar("s4_nivel_n", nn, esp);
      esp = {7};
      revisar("s4_pulso_n", pn, esp);
      mantener(1'b0, 2);

      // Reset on edges 9-10 during a hold: re-detected press pulses at edge 17.
      inicio();
      mantener(1'b1, 8);
      paso(1'b1, 1'b1);
      verificar("s5_rst1_pulso", int'(pulso_r), 0);
      verificar("s5_rst1_nivel", int'(nivel_r), 0);
      paso(1'b1, 1'b1);
      verificar("s5_rst2_pulso", int'(pulso_r), 0);
      verificar("s5_rst2_nivel", int'(nivel_r), 0);
      mantener(1'b1, 12);
      mantener(1'b0, 10);
      esp = {7, 17};
      revisar("s5_pulso_r", pr, esp);
      revisar("s5_pulso_n", pn, esp);
      esp = {7, 9, 17, 29};
      revisar("s5_nivel_r", nr, esp);
      mantener(1'b0, 2);

      // Long hold with repetition disabled: a single pulse.
      inicio();
      mantener(1'b1, 200);
      mantener(1'b0, 10);
      esp = {7};
      revisar("s6_pulso_n", pn, esp);
      esp = {7, 207};
      revisar("s6_nivel_n", nn, esp);

      $display("%0d/%0d checks passed", pasadas, total);
      $finish;
   end

endmodule
